// File: rtl/fpdiv.sv
// Sequential floating-point divider: 26-step restoring mantissa division,
// start/done handshake, hidden-1 mantissas, zero word treated as zero.
module fpdiv #(
    parameter int m = 23,
    parameter int e = 8,
    parameter int p = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [p-1:0] Num1,
    input  logic [p-1:0] Num2,
    output logic         busy,
    output logic         done,
    output logic [p-1:0] final_val,
    output logic         div_by_zero
);

    localparam int CW = $clog2(m + 3);
    localparam logic [CW-1:0] LAST = CW'(m + 2);
    localparam logic [e-1:0] BIAS_HI = e'((1 << (e - 1)) - 1);
    localparam logic [e-1:0] BIAS_LO = e'((1 << (e - 1)) - 2);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t state, state_d;

    logic           s, s_d;
    logic [e-1:0]   ea, ea_d, eb, eb_d;
    logic [m+1:0]   r, r_d;
    logic [m:0]     v, v_d;
    logic [m+2:0]   q, q_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic [p-1:0]   res, res_d;
    logic           dzp, dzp_d;
    logic           busy_d, done_d, dz_d;
    logic [p-1:0]   final_d;

    logic           ge;
    logic [m+1:0]   r_step;
    logic [m+2:0]   q_step;
    logic [m-1:0]   man_n;
    logic           rb;
    logic [e-1:0]   exp_n, exp_f;
    logic [m:0]     man_r;
    logic           s_new;

    // Datapath arithmetic: one restoring step and the normalise/round result
    always_comb begin
        ge     = (r >= {1'b0, v});
        r_step = ge ? ((r - {1'b0, v}) << 1) : (r << 1);
        q_step = {q[m+1:0], ge};
        if (q[m+2]) begin
            man_n = q[m+1:2];
            rb    = q[1];
            exp_n = ea - eb + BIAS_HI;
        end else begin
            man_n = q[m:1];
            rb    = q[0];
            exp_n = ea - eb + BIAS_LO;
        end
        man_r = {1'b0, man_n} + {{m{1'b0}}, rb};
        exp_f = man_r[m] ? exp_n + 1'b1 : exp_n;
        s_new = Num1[p-1] ^ Num2[p-1];
    end

    // Next-state and next-output logic for the divider FSM
    always_comb begin
        state_d = state;
        s_d     = s;
        ea_d    = ea;
        eb_d    = eb;
        r_d     = r;
        v_d     = v;
        q_d     = q;
        cnt_d   = cnt;
        res_d   = res;
        dzp_d   = dzp;
        busy_d  = busy;
        done_d  = 1'b0;
        final_d = final_val;
        dz_d    = div_by_zero;
        unique case (state)
            IDLE: begin
                if (start) begin
                    s_d    = s_new;
                    ea_d   = Num1[p-2:m];
                    eb_d   = Num2[p-2:m];
                    r_d    = {1'b0, 1'b1, Num1[m-1:0]};
                    v_d    = {1'b1, Num2[m-1:0]};
                    q_d    = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (Num1 == '0) begin
                        res_d   = '0;
                        dzp_d   = 1'b0;
                        state_d = DONE;
                    end else if (Num2 == '0) begin
                        res_d   = {s_new, {e{1'b1}}, {m{1'b0}}};
                        dzp_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt + 1'b1;
                if (cnt == LAST) state_d = NORM;
            end
            NORM: begin
                res_d   = {s, exp_f, man_r[m-1:0]};
                dzp_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                final_d = res;
                dz_d    = dzp;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s           <= 1'b0;
            ea          <= '0;
            eb          <= '0;
            r           <= '0;
            v           <= '0;
            q           <= '0;
            cnt         <= '0;
            res         <= '0;
            dzp         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            final_val   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_d;
            s           <= s_d;
            ea          <= ea_d;
            eb          <= eb_d;
            r           <= r_d;
            v           <= v_d;
            q           <= q_d;
            cnt         <= cnt_d;
            res         <= res_d;
            dzp         <= dzp_d;
            busy        <= busy_d;
            done        <= done_d;
            final_val   <= final_d;
            div_by_zero <= dz_d;
        end
    end

endmodule

// File: tb/tb_fpdiv.sv
// Directed testbench for fpdiv: results, latency, zero cases,
// handshake filtering, back-to-back requests and mid-operation reset.
module tb_fpdiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] num1 = '0;
    logic [31:0] num2 = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] final_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpdiv dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .Num1(num1),
        .Num2(num2),
        .busy(busy),
        .done(done),
        .final_val(final_val),
        .div_by_zero(div_by_zero)
    );

    // Issue one request and wait (bounded) for done; reports latency
    // from the accepting edge and the number of cycles busy was high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcyc);
        num1 = a;
        num2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        num1 = '1;
        num2 = '1;
        bcyc = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset busy: got %b expected 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset done: got %b expected 0", done);
        end
        checks++;
        if (final_val !== 32'h0) begin
            errors++;
            $display("FAIL reset final: got %h expected 0", final_val);
        end
        checks++;
        if (div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset dbz: got %b expected 0", div_by_zero);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_normal;
        logic [31:0] va[3];
        logic [31:0] vb[3];
        logic [31:0] vq[3];
        int lat;
        int bcyc;
        va[0] = 32'h40C00000; vb[0] = 32'h40000000; vq[0] = 32'h40400000;
        va[1] = 32'h3F800000; vb[1] = 32'h40400000; vq[1] = 32'h3EAAAAAB;
        va[2] = 32'hBFC00000; vb[2] = 32'h3F000000; vq[2] = 32'hC0400000;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], lat, bcyc);
            checks++;
            if (final_val !== vq[i]) begin
                errors++;
                $display("FAIL normal[%0d] final: got %h expected %h",
                         i, final_val, vq[i]);
            end
            checks++;
            if (div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL normal[%0d] dbz: got %b expected 0",
                         i, div_by_zero);
            end
            checks++;
            if (lat !== 28) begin
                errors++;
                $display("FAIL normal[%0d] latency: got %0d expected 28",
                         i, lat);
            end
            checks++;
            if (bcyc !== 28) begin
                errors++;
                $display("FAIL normal[%0d] busy cycles: got %0d expected 28",
                         i, bcyc);
            end
            if (i == 0) begin
                @(posedge clk);
                #1;
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL done pulse width: got %b expected 0", done);
                end
            end
        end
    endtask

    task automatic test_zero;
        logic [31:0] va[3];
        logic [31:0] vb[3];
        logic [31:0] vq[3];
        logic        vz[3];
        int lat;
        int bcyc;
        va[0] = 32'h00000000; vb[0] = 32'h40A00000;
        vq[0] = 32'h00000000; vz[0] = 1'b0;
        va[1] = 32'h00000000; vb[1] = 32'h00000000;
        vq[1] = 32'h00000000; vz[1] = 1'b0;
        va[2] = 32'h40A00000; vb[2] = 32'h00000000;
        vq[2] = 32'h7F800000; vz[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], lat, bcyc);
            checks++;
            if (final_val !== vq[i]) begin
                errors++;
                $display("FAIL zero[%0d] final: got %h expected %h",
                         i, final_val, vq[i]);
            end
            checks++;
            if (div_by_zero !== vz[i]) begin
                errors++;
                $display("FAIL zero[%0d] dbz: got %b expected %b",
                         i, div_by_zero, vz[i]);
            end
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL zero[%0d] latency: got %0d expected 1", i, lat);
            end
            checks++;
            if (bcyc !== 1) begin
                errors++;
                $display("FAIL zero[%0d] busy cycles: got %0d expected 1",
                         i, bcyc);
            end
        end
    endtask

    task automatic test_handshake;
        int ndone = 0;
        int first = -1;
        num1 = 32'h40400000;
        num2 = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            start = (c == 5);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) first = c;
            end
            if (c == 10) begin
                checks++;
                if (final_val !== 32'h7F800000 || div_by_zero !== 1'b1) begin
                    errors++;
                    $display("FAIL hold while busy: got %h/%b expected 7f800000/1",
                             final_val, div_by_zero);
                end
            end
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL handshake done count: got %0d expected 1", ndone);
        end
        checks++;
        if (first !== 28) begin
            errors++;
            $display("FAIL handshake latency: got %0d expected 28", first);
        end
        checks++;
        if (final_val !== 32'h3FC00000) begin
            errors++;
            $display("FAIL handshake final: got %h expected 3fc00000", final_val);
        end
        checks++;
        if (div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL handshake dbz: got %b expected 0", div_by_zero);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] va[3];
        logic [31:0] vb[3];
        logic [31:0] vq[3];
        logic        vz[3];
        int          vl[3];
        int lat;
        int bcyc;
        va[0] = 32'h3F800000; vb[0] = 32'h40400000;
        vq[0] = 32'h3EAAAAAB; vz[0] = 1'b0; vl[0] = 28;
        va[1] = 32'h40A00000; vb[1] = 32'h00000000;
        vq[1] = 32'h7F800000; vz[1] = 1'b1; vl[1] = 1;
        va[2] = 32'h40C00000; vb[2] = 32'h40000000;
        vq[2] = 32'h40400000; vz[2] = 1'b0; vl[2] = 28;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], lat, bcyc);
            checks++;
            if (final_val !== vq[i]) begin
                errors++;
                $display("FAIL b2b[%0d] final: got %h expected %h",
                         i, final_val, vq[i]);
            end
            checks++;
            if (div_by_zero !== vz[i]) begin
                errors++;
                $display("FAIL b2b[%0d] dbz: got %b expected %b",
                         i, div_by_zero, vz[i]);
            end
            checks++;
            if (lat !== vl[i]) begin
                errors++;
                $display("FAIL b2b[%0d] latency: got %0d expected %0d",
                         i, lat, vl[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        int ndone = 0;
        int lat;
        int bcyc;
        num1 = 32'h40C00000;
        num2 = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset busy: got %b expected 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midreset done: got %b expected 0", done);
        end
        checks++;
        if (final_val !== 32'h0) begin
            errors++;
            $display("FAIL midreset final: got %h expected 0", final_val);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL midreset stray done: got %0d expected 0", ndone);
        end
        run_op(32'h40C00000, 32'h40000000, lat, bcyc);
        checks++;
        if (final_val !== 32'h40400000) begin
            errors++;
            $display("FAIL after reset final: got %h expected 40400000",
                     final_val);
        end
        checks++;
        if (lat !== 28) begin
            errors++;
            $display("FAIL after reset latency: got %0d expected 28", lat);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_normal();
        test_zero();
        test_handshake();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
